// File: rtl/coeff_bank_controller_pkg.sv
// Shared constants and FSM encoding for the beamformer lane coefficient controller.
package coeff_bank_controller_pkg;

  localparam int LANE_CH      = 24;
  localparam int LANE_COEFF_W = 16;

  localparam logic [15:0] COEFF_UNITY_I = 16'h7FFF;
  localparam logic [15:0] COEFF_UNITY_Q = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

endpackage

// File: rtl/coeff_bank_regs.sv
// Shadow/active coefficient banks: host write decode into shadow, bulk copy into active,
// and flat packing of the active bank for the multiplier array.
module coeff_bank_regs
  import coeff_bank_controller_pkg::*;
#(
  parameter int NUM_CH       = LANE_CH,
  parameter int COEFF_WIDTH  = LANE_COEFF_W,
  parameter int CH_IDX_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [CH_IDX_WIDTH-1:0]       wr_ch,
  input  logic [COEFF_WIDTH-1:0]        wr_coeff_i,
  input  logic [COEFF_WIDTH-1:0]        wr_coeff_q,
  input  logic                          copy_en,
  output logic [NUM_CH*COEFF_WIDTH-1:0] coeff_i_packed,
  output logic [NUM_CH*COEFF_WIDTH-1:0] coeff_q_packed,
  output logic                          wr_err
);

  localparam logic signed [COEFF_WIDTH-1:0] UNITY_I = COEFF_WIDTH'(COEFF_UNITY_I);
  localparam logic signed [COEFF_WIDTH-1:0] UNITY_Q = COEFF_WIDTH'(COEFF_UNITY_Q);

  logic signed [COEFF_WIDTH-1:0] shadow_i [NUM_CH];
  logic signed [COEFF_WIDTH-1:0] shadow_q [NUM_CH];
  logic signed [COEFF_WIDTH-1:0] active_i [NUM_CH];
  logic signed [COEFF_WIDTH-1:0] active_q [NUM_CH];
  logic                          ch_ok;

  // One extra bit so NUM_CH == 2^CH_IDX_WIDTH does not wrap to zero.
  assign ch_ok = {1'b0, wr_ch} < (CH_IDX_WIDTH+1)'(NUM_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_i[k] <= UNITY_I;
        shadow_q[k] <= UNITY_Q;
        active_i[k] <= UNITY_I;
        active_q[k] <= UNITY_Q;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en && (wr_ch == CH_IDX_WIDTH'(k))) begin
          shadow_i[k] <= $signed(wr_coeff_i);
          shadow_q[k] <= $signed(wr_coeff_q);
        end
        if (copy_en) begin
          active_i[k] <= shadow_i[k];
          active_q[k] <= shadow_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= wr_en && !ch_ok;
  end

  always_comb begin
    coeff_i_packed = '0;
    coeff_q_packed = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      coeff_i_packed[k*COEFF_WIDTH +: COEFF_WIDTH] = active_i[k];
      coeff_q_packed[k*COEFF_WIDTH +: COEFF_WIDTH] = active_q[k];
    end
  end

endmodule

// File: rtl/coeff_bank_controller.sv
// Double-buffered coefficient controller: commits swap shadow into active only at a frame boundary.
// Optional armed-state timeout forcing a swap is enabled by defining COEFF_CTRL_TIMEOUT_EN.
module coeff_bank_controller
  import coeff_bank_controller_pkg::*;
#(
  parameter int NUM_CH         = LANE_CH,
  parameter int COEFF_WIDTH    = LANE_COEFF_W,
  parameter int CH_IDX_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_wr_valid,
  output logic                          cfg_wr_ready,
  input  logic [CH_IDX_WIDTH-1:0]       cfg_wr_ch,
  input  logic [COEFF_WIDTH-1:0]        cfg_wr_coeff_i,
  input  logic [COEFF_WIDTH-1:0]        cfg_wr_coeff_q,
  input  logic                          cfg_commit,
  input  logic                          frame_start,
  output logic [NUM_CH*COEFF_WIDTH-1:0] coeff_i_packed,
  output logic [NUM_CH*COEFF_WIDTH-1:0] coeff_q_packed,
  output logic                          swap_done,
  output logic                          cfg_err,
  output logic                          armed,
  output logic                          swap_timeout
);

  state_t state, state_nxt;
  logic   wr_fire;
  logic   copy_en;
  logic   timeout_hit;

  assign wr_fire = cfg_wr_valid && cfg_wr_ready;
  assign copy_en = (state == ST_SWAP);

`ifdef COEFF_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_flag;

  assign timeout_hit = (state == ST_ARMED) && !frame_start &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside ARMED, so every entry starts a fresh wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt      <= '0;
      tmo_flag     <= 1'b0;
      swap_timeout <= 1'b0;
    end else begin
      tmo_cnt      <= (state == ST_ARMED) ? tmo_cnt + CNT_W'(1) : '0;
      tmo_flag     <= (state == ST_ARMED) ? timeout_hit : tmo_flag;
      swap_timeout <= copy_en && tmo_flag;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign swap_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_commit) state_nxt = ST_ARMED;
      ST_ARMED: if (frame_start || timeout_hit) state_nxt = ST_SWAP;
      ST_SWAP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cfg_wr_ready <= 1'b0;
      armed        <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cfg_wr_ready <= (state_nxt == ST_IDLE);
      armed        <= (state_nxt == ST_ARMED);
      swap_done    <= copy_en;
    end
  end

  coeff_bank_regs #(
    .NUM_CH       (NUM_CH),
    .COEFF_WIDTH  (COEFF_WIDTH),
    .CH_IDX_WIDTH (CH_IDX_WIDTH)
  ) u_regs (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_fire),
    .wr_ch          (cfg_wr_ch),
    .wr_coeff_i     (cfg_wr_coeff_i),
    .wr_coeff_q     (cfg_wr_coeff_q),
    .copy_en        (copy_en),
    .coeff_i_packed (coeff_i_packed),
    .coeff_q_packed (coeff_q_packed),
    .wr_err         (cfg_err)
  );

endmodule
